// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with serial/parallel load,
// direction-aware shift counting and a full-word pulse.
// Define SHIFT_REG_ROTATE_EN to build in the rotate modes (100/101);
// without it those encodings hold like 000.
module shift_reg_univ #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             word_valid,
  output logic [CW-1:0]    shift_cnt
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  dir_t          last_dir;
  dir_t          req_dir;
  logic          same_dir;
  logic          cnt_wrap;
  logic [CW-1:0] shift_cnt_next;
  logic          word_done;

  // Work out the count/pulse outcome a shift would have this cycle.
  always_comb begin
    req_dir        = (mode == MODE_SHR) ? DIR_RIGHT : DIR_LEFT;
    same_dir       = (req_dir == last_dir);
    cnt_wrap       = (shift_cnt == CW'(WIDTH - 1));
    shift_cnt_next = CW'(1);
    word_done      = 1'b0;
    if (same_dir) begin
      shift_cnt_next = cnt_wrap ? '0 : shift_cnt + CW'(1);
      word_done      = cnt_wrap;
    end
  end

  // Register update: synchronous reset first, then the selected operation.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      out        <= '0;
      ser_out    <= 1'b0;
      word_valid <= 1'b0;
      shift_cnt  <= '0;
      last_dir   <= DIR_LEFT;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge out/shift_cnt; a default here makes word_valid a 1-cycle pulse.
      word_valid <= 1'b0;
      if (en) begin
        case (mode)
          MODE_SHL: begin
            out        <= {out[WIDTH-2:0], ser_in};
            ser_out    <= out[WIDTH-1];
            shift_cnt  <= shift_cnt_next;
            word_valid <= word_done;
            last_dir   <= DIR_LEFT;
          end
          MODE_SHR: begin
            out        <= {ser_in, out[WIDTH-1:1]};
            ser_out    <= out[0];
            shift_cnt  <= shift_cnt_next;
            word_valid <= word_done;
            last_dir   <= DIR_RIGHT;
          end
          MODE_LOAD: begin
            out       <= par_in;
            shift_cnt <= '0;
          end
`ifdef SHIFT_REG_ROTATE_EN
          MODE_ROL: begin
            out     <= {out[WIDTH-2:0], out[WIDTH-1]};
            ser_out <= out[WIDTH-1];
          end
          MODE_ROR: begin
            out     <= {out[0], out[WIDTH-1:1]};
            ser_out <= out[0];
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits, legal range 2..64.
REQ-002 SHALL have localparam CW = $clog2(WIDTH), the shift-count width.
REQ-003 SHALL have port clk_50M, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: operation enable.
REQ-006 SHALL have port mode, input, 3 bits: operation select, encoded per REQ-012.
REQ-007 SHALL have port ser_in, input, 1 bit: serial data in.
REQ-008 SHALL have port par_in, input, WIDTH bits: parallel load data.
REQ-009 SHALL have port out, output, WIDTH bits: register contents, driven from a register.
REQ-010 SHALL have port ser_out, output, 1 bit: last bit shifted out, registered.
REQ-011 SHALL have ports word_valid (output, 1 bit: full-word pulse) and shift_cnt (output, CW bits: shifts in current word).

Function
REQ-012 SHALL decode mode as: 000 hold; 001 shift left, ser_in into LSB; 010 shift right, ser_in into MSB; 011 parallel load from par_in; 100 rotate left; 101 rotate right; 110/111 hold.
REQ-013 SHALL update out on the same clock edge where en=1 and a non-hold mode is sampled (latency 1 edge).
REQ-014 SHALL hold all state when en=0; word_valid SHALL be 0 in the cycle after any edge with en=0.
REQ-015 SHALL load ser_out with the discarded bit on each shift (old MSB on left, old LSB on right), and SHALL otherwise hold ser_out; a parallel load SHALL NOT change it.
REQ-016 SHALL track the last shift direction (last_dir); on a shift in the same direction as last_dir, shift_cnt SHALL increment, wrapping from WIDTH-1 to 0.
REQ-017 SHALL pulse word_valid for exactly one cycle after the edge on which shift_cnt wraps to 0, coincident with out showing the completed word.
REQ-018 SHALL, on a shift opposite to last_dir, set shift_cnt=1, update last_dir, and leave word_valid at 0.
REQ-019 SHALL, on a parallel load, set shift_cnt=0 and word_valid=0, and leave last_dir unchanged.
REQ-020 SHALL NOT change shift_cnt, last_dir or word_valid on rotates or hold; word_valid SHALL be 0 after such edges.
REQ-021 SHALL treat simultaneous reset=0 and en=1 as reset; reset has priority over every mode.

Reset
REQ-022 SHALL, on a rising edge with reset=0, set out=0, ser_out=0, word_valid=0, shift_cnt=0 and last_dir=left.
REQ-023 SHALL ignore reset assertion between edges; a mid-word reset SHALL abandon the partial word with no word_valid pulse.

Configuration
REQ-024 SHALL compile the rotate modes (100/101) in when macro SHIFT_REG_ROTATE_EN is defined.
REQ-025 SHALL, when SHIFT_REG_ROTATE_EN is undefined, treat modes 100/101 as hold; all other behaviour is unchanged.

Verification
REQ-026 SHALL cover reset: hold reset=0 for 1 edge with en=1, mode=001 -> out=0x00, ser_out=0, word_valid=0, shift_cnt=0.
REQ-027 SHALL cover the left shift word: en=1, mode=001, ser_in=1 for 8 edges -> out 0x01,0x03..0xFF, word_valid high only after the 8th edge; then ser_in=0 for 8 edges -> out 0xFE..0x00, second pulse.
REQ-028 SHALL cover load then right shift: load par_in=0xA5, then mode=010, ser_in=0 for 3 edges -> out 0x52,0x29,0x14; ser_out 1,0,1; shift_cnt=3.
REQ-029 SHALL cover rotate: load 0x81, mode=100 for 1 edge -> out=0x03, ser_out=1 with SHIFT_REG_ROTATE_EN; out stays 0x81 without it.
REQ-030 SHALL cover direction change: 5 left shifts then 1 right -> shift_cnt=1, no pulse; 7 further right shifts -> word_valid pulses after the 7th.
REQ-031 SHALL cover hold and mid-word reset: en=0 for 4 edges mid-word -> out and shift_cnt frozen; reset=0 at shift_cnt=5 -> all outputs 0 next cycle, no pulse.
